// File: rtl/dfx_seq_pkg.sv
// Shared types and default timing constants for the DFX reconfigurable
// partition shutdown sequencer.
package dfx_seq_pkg;

    // Sequencer states; the encodings are visible on the debug port.
    typedef enum logic [2:0] {
        ST_ACTIVE   = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_DECOUPLE = 3'd2,
        ST_GATE     = 3'd3,
        ST_WAIT_CFG = 3'd4,
        ST_RESTART  = 3'd5,
        ST_RELEASE  = 3'd6
    } seq_state_t;

    // Default cycle counts for the drain, settle and reset-hold intervals.
    localparam int DEF_DRAIN_TIMEOUT    = 1024;
    localparam int DEF_CE_SETTLE_CYCLES = 8;
    localparam int DEF_RST_HOLD_CYCLES  = 16;
    localparam int DEF_CNT_W            = 11;

    // Largest of three cycle counts, used to size-check the counter width.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dfx_seq_counter.sv
// Loadable saturating down-counter with a terminal-count flag. The
// sequencer loads it on every state change with the number of cycles the
// new state should last; tc rises once the count has run down to zero.
module dfx_seq_counter #(
    parameter int CNT_W       = 11,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    // Load on request, otherwise count down and hold at zero (never wraps).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= CNT_W'(RESET_VALUE);
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dfx_rp_shutdown_sequencer.sv
// Shutdown/restart sequencer for the reconfigurable partition feeding the
// DDR4 NoC path. Drains RP traffic, decouples, gates the RP clock, waits for
// the partial bitstream, then re-enables the clock and releases reset.
module dfx_rp_shutdown_sequencer
    import dfx_seq_pkg::*;
#(
    parameter int DRAIN_TIMEOUT    = DEF_DRAIN_TIMEOUT,
    parameter int CE_SETTLE_CYCLES = DEF_CE_SETTLE_CYCLES,
    parameter int RST_HOLD_CYCLES  = DEF_RST_HOLD_CYCLES,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic       clk_in1,
    input  logic       ext_reset_in,
    input  logic       shutdown_req,
    output logic       shutdown_ack,
    input  logic       reconfig_done,
    input  logic       rp_idle,
    output logic       decouple,
    output logic       ce_out,
    output logic       rp_reset_n,
    output logic       timeout_err,
    output logic [2:0] state_o
);

    if ((1 << CNT_W) <= max3(DRAIN_TIMEOUT, CE_SETTLE_CYCLES, RST_HOLD_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too small for the configured cycle counts");
    end

    seq_state_t       state;
    seq_state_t       next_state;
    logic             drain_timeout;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_tc;

    // Transition rules; in DRAIN an abort beats rp_idle, which beats timeout.
    always_comb begin
        next_state    = state;
        drain_timeout = 1'b0;
        case (state)
            ST_ACTIVE: begin
                if (shutdown_req) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!shutdown_req) begin
                    next_state = ST_ACTIVE;
                end else if (rp_idle) begin
                    next_state = ST_DECOUPLE;
                end else if (cnt_tc) begin
                    next_state    = ST_DECOUPLE;
                    drain_timeout = 1'b1;
                end
            end
            ST_DECOUPLE: begin
                if (cnt_tc) next_state = ST_GATE;
            end
            ST_GATE: begin
                next_state = ST_WAIT_CFG;
            end
            ST_WAIT_CFG: begin
                if (reconfig_done) next_state = ST_RESTART;
            end
            ST_RESTART: begin
                if (cnt_tc) next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (cnt_tc) next_state = ST_ACTIVE;
            end
            default: begin
                next_state = ST_RESTART;
            end
        endcase
    end

    // Reload the interval counter whenever the state changes. DECOUPLE gets
    // one extra cycle because its decouple output lags the state by a cycle.
    always_comb begin
        cnt_load  = (next_state != state);
        cnt_value = '0;
        case (next_state)
            ST_DRAIN:    cnt_value = CNT_W'(DRAIN_TIMEOUT - 1);
            ST_DECOUPLE: cnt_value = CNT_W'(CE_SETTLE_CYCLES);
            ST_RESTART:  cnt_value = CNT_W'(RST_HOLD_CYCLES - 1);
            ST_RELEASE:  cnt_value = CNT_W'(CE_SETTLE_CYCLES - 1);
            default:     cnt_value = '0;
        endcase
    end

    // Out of reset the counter already holds the RESTART hold interval,
    // because the RM is present in the full bitstream.
    dfx_seq_counter #(
        .CNT_W      (CNT_W),
        .RESET_VALUE(RST_HOLD_CYCLES - 1)
    ) u_counter (
        .clk       (clk_in1),
        .rst_n     (ext_reset_in),
        .load      (cnt_load),
        .load_value(cnt_value),
        .tc        (cnt_tc)
    );

    // State register plus registered outputs driven from the state being entered.
    always_ff @(posedge clk_in1 or negedge ext_reset_in) begin
        if (!ext_reset_in) begin
            state        <= ST_RESTART;
            ce_out       <= 1'b1;
            decouple     <= 1'b1;
            rp_reset_n   <= 1'b0;
            shutdown_ack <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= next_state;
            case (next_state)
                ST_ACTIVE: begin
                    ce_out       <= 1'b1;
                    decouple     <= 1'b0;
                    rp_reset_n   <= 1'b1;
                    shutdown_ack <= 1'b0;
                    timeout_err  <= 1'b0;
                end
                ST_DRAIN: begin
                    ce_out       <= 1'b1;
                    decouple     <= 1'b0;
                    rp_reset_n   <= 1'b1;
                    shutdown_ack <= 1'b0;
                end
                ST_DECOUPLE: begin
                    ce_out       <= 1'b1;
                    decouple     <= (state == ST_DECOUPLE);
                    rp_reset_n   <= 1'b1;
                    shutdown_ack <= 1'b0;
                    if (drain_timeout) timeout_err <= 1'b1;
                end
                ST_GATE, ST_WAIT_CFG: begin
                    ce_out       <= 1'b0;
                    decouple     <= 1'b1;
                    rp_reset_n   <= 1'b0;
                    shutdown_ack <= 1'b1;
                end
                ST_RESTART: begin
                    ce_out       <= 1'b1;
                    decouple     <= 1'b1;
                    rp_reset_n   <= 1'b0;
                    shutdown_ack <= 1'b0;
                end
                ST_RELEASE: begin
                    ce_out       <= 1'b1;
                    decouple     <= 1'b1;
                    rp_reset_n   <= 1'b1;
                    shutdown_ack <= 1'b0;
                end
                default: begin
                    ce_out       <= 1'b1;
                    decouple     <= 1'b1;
                    rp_reset_n   <= 1'b0;
                    shutdown_ack <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_dfx_rp_shutdown_sequencer.sv
// Self-checking bench for dfx_rp_shutdown_sequencer: hand-written timelines,
// a table of clean-shutdown vectors, and randomized traffic checked against
// a phase/age reference model.
module tb_dfx_rp_shutdown_sequencer;

    localparam int DT = 1024;
    localparam int CS = 8;
    localparam int RH = 16;

    localparam int P_ACTIVE   = 0;
    localparam int P_DRAIN    = 1;
    localparam int P_DECOUPLE = 2;
    localparam int P_GATE     = 3;
    localparam int P_WAIT     = 4;
    localparam int P_RESTART  = 5;
    localparam int P_RELEASE  = 6;

    logic       clk_in1       = 1'b0;
    logic       ext_reset_in  = 1'b1;
    logic       shutdown_req  = 1'b0;
    logic       reconfig_done = 1'b0;
    logic       rp_idle       = 1'b0;
    logic       shutdown_ack;
    logic       decouple;
    logic       ce_out;
    logic       rp_reset_n;
    logic       timeout_err;
    logic [2:0] state_o;

    int vectors     = 0;
    int miscompares = 0;

    int m_phase = P_RESTART;
    int m_age   = 0;
    bit m_terr  = 1'b0;

    typedef struct {
        bit          req;
        bit          idle;
        bit          done;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    dfx_rp_shutdown_sequencer #(
        .DRAIN_TIMEOUT   (DT),
        .CE_SETTLE_CYCLES(CS),
        .RST_HOLD_CYCLES (RH),
        .CNT_W           (11)
    ) dut (
        .clk_in1      (clk_in1),
        .ext_reset_in (ext_reset_in),
        .shutdown_req (shutdown_req),
        .shutdown_ack (shutdown_ack),
        .reconfig_done(reconfig_done),
        .rp_idle      (rp_idle),
        .decouple     (decouple),
        .ce_out       (ce_out),
        .rp_reset_n   (rp_reset_n),
        .timeout_err  (timeout_err),
        .state_o      (state_o)
    );

    always #5 clk_in1 = ~clk_in1;

    // Reference model: a phase plus the number of cycles spent in it.
    always @(posedge clk_in1 or negedge ext_reset_in) begin : model
        int np;
        if (!ext_reset_in) begin
            m_phase = P_RESTART;
            m_age   = 0;
            m_terr  = 1'b0;
        end else begin
            np = m_phase;
            case (m_phase)
                P_ACTIVE:   if (shutdown_req) np = P_DRAIN;
                P_DRAIN: begin
                    if (!shutdown_req) np = P_ACTIVE;
                    else if (rp_idle) np = P_DECOUPLE;
                    else if (m_age == DT - 1) begin
                        np = P_DECOUPLE;
                        m_terr = 1'b1;
                    end
                end
                P_DECOUPLE: if (m_age == CS) np = P_GATE;
                P_GATE:     np = P_WAIT;
                P_WAIT:     if (reconfig_done) np = P_RESTART;
                P_RESTART:  if (m_age == RH - 1) np = P_RELEASE;
                P_RELEASE: begin
                    if (m_age == CS - 1) begin
                        np = P_ACTIVE;
                        m_terr = 1'b0;
                    end
                end
                default:    np = P_RESTART;
            endcase
            if (np != m_phase) begin
                m_phase = np;
                m_age   = 0;
            end else begin
                m_age = m_age + 1;
            end
        end
    end

    function automatic logic [7:0] pack(input int st, input bit ce, input bit dec,
                                        input bit rstn, input bit ack, input bit terr);
        return {3'(st), ce, dec, rstn, ack, terr};
    endfunction

    function automatic logic [7:0] modelExpected();
        case (m_phase)
            P_ACTIVE, P_DRAIN: return pack(m_phase, 1, 0, 1, 0, m_terr);
            P_DECOUPLE:        return pack(m_phase, 1, m_age >= 1, 1, 0, m_terr);
            P_GATE, P_WAIT:    return pack(m_phase, 0, 1, 0, 1, m_terr);
            P_RESTART:         return pack(m_phase, 1, 1, 0, 0, m_terr);
            P_RELEASE:         return pack(m_phase, 1, 1, 1, 0, m_terr);
            default:           return 8'hxx;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {state_o, ce_out, decouple, rp_reset_n, shutdown_ack, timeout_err};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: {state,ce,dec,rstn,ack,terr} got %b_%b%b%b%b%b expected %b_%b%b%b%b%b",
                     name, act[7:5], act[4], act[3], act[2], act[1], act[0],
                     exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic applyStimulus(input bit req, input bit idle, input bit done);
        shutdown_req  = req;
        rp_idle       = idle;
        reconfig_done = done;
        @(posedge clk_in1);
        @(negedge clk_in1);
    endtask

    // Restart timeline after the RESTART entry edge: reset held, then settle.
    task automatic checkRestartSequence(input string prefix, input bit terr_in);
        for (int k = 1; k <= RH + CS; k++) begin
            int st;
            applyStimulus(0, 0, 0);
            st = (k < RH) ? P_RESTART : ((k < RH + CS) ? P_RELEASE : P_ACTIVE);
            checkOutput($sformatf("%s_%0d", prefix, k),
                        pack(st, 1, k < RH + CS, k >= RH, 0, (k < RH + CS) ? terr_in : 1'b0));
        end
    endtask

    task automatic runUntilPhase(input int target, input bit req, input bit idle,
                                 input int max_cycles, input string name);
        int n = 0;
        while (m_phase != target && n < max_cycles) begin
            applyStimulus(req, idle, 0);
            checkOutput(name, modelExpected());
            n++;
        end
        if (m_phase != target) begin
            miscompares++;
            $display("[TB] FAIL %s: phase %0d not reached within %0d cycles", name, target, max_cycles);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit rreq;

        // Reset held: outputs at their power-on values.
        ext_reset_in = 1'b0;
        repeat (3) @(negedge clk_in1);
        checkOutput("reset_values", pack(P_RESTART, 1, 1, 0, 0, 0));

        // Power-up restart sequence.
        ext_reset_in = 1'b1;
        checkRestartSequence("powerup", 1'b0);

        // Stray reconfig_done while ACTIVE is ignored.
        applyStimulus(0, 1, 1);
        checkOutput("stray_done", pack(P_ACTIVE, 1, 0, 1, 0, 0));
        applyStimulus(0, 1, 0);
        checkOutput("stray_done_after", pack(P_ACTIVE, 1, 0, 1, 0, 0));

        // Clean shutdown and reconfiguration, one table row per clock.
        tbl.push_back('{1'b1, 1'b1, 1'b0, pack(P_DRAIN, 1, 0, 1, 0, 0), "clean_drain"});
        tbl.push_back('{1'b1, 1'b1, 1'b0, pack(P_DECOUPLE, 1, 0, 1, 0, 0), "clean_decouple_entry"});
        for (int i = 0; i < CS; i++)
            tbl.push_back('{1'b1, 1'b1, 1'b0, pack(P_DECOUPLE, 1, 1, 1, 0, 0), "clean_decouple_settle"});
        tbl.push_back('{1'b1, 1'b1, 1'b0, pack(P_GATE, 0, 1, 0, 1, 0), "clean_gate_ack"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, pack(P_WAIT, 0, 1, 0, 1, 0), "clean_wait_cfg"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, pack(P_WAIT, 0, 1, 0, 1, 0), "clean_wait_hold"});
        tbl.push_back('{1'b0, 1'b0, 1'b1, pack(P_RESTART, 1, 1, 0, 0, 0), "reconfig_done_restart"});
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].req, tbl[i].idle, tbl[i].done);
            checkOutput($sformatf("%s_%0d", tbl[i].name, i), tbl[i].exp);
        end
        checkRestartSequence("reconfig_restart", 1'b0);

        // Abort in DRAIN after five cycles.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("abort_drain_hold", pack(P_DRAIN, 1, 0, 1, 0, 0));
        end
        applyStimulus(0, 0, 0);
        checkOutput("abort_back_active", pack(P_ACTIVE, 1, 0, 1, 0, 0));

        // Drain timeout with rp_idle held low.
        applyStimulus(1, 0, 0);
        checkOutput("timeout_drain_entry", pack(P_DRAIN, 1, 0, 1, 0, 0));
        for (int k = 1; k < DT; k++) begin
            applyStimulus(1, 0, 0);
            checkOutput("timeout_drain", modelExpected());
        end
        applyStimulus(1, 0, 0);
        checkOutput("timeout_decouple_entry", pack(P_DECOUPLE, 1, 0, 1, 0, 1));
        for (int i = 0; i < CS; i++) begin
            applyStimulus(1, 0, 0);
            checkOutput("timeout_decouple_settle", pack(P_DECOUPLE, 1, 1, 1, 0, 1));
        end
        applyStimulus(1, 0, 0);
        checkOutput("timeout_gate_ack", pack(P_GATE, 0, 1, 0, 1, 1));
        applyStimulus(0, 0, 0);
        checkOutput("timeout_wait_cfg", pack(P_WAIT, 0, 1, 0, 1, 1));
        applyStimulus(0, 0, 1);
        checkOutput("timeout_restart_entry", pack(P_RESTART, 1, 1, 0, 0, 1));
        checkRestartSequence("timeout_restart", 1'b1);

        // Reset asserted mid-cycle while waiting for the bitstream.
        runUntilPhase(P_WAIT, 1, 1, 40, "reach_wait_cfg");
        #2 ext_reset_in = 1'b0;
        #1 checkOutput("async_reset_values", pack(P_RESTART, 1, 1, 0, 0, 0));
        @(negedge clk_in1);
        shutdown_req = 1'b0;
        ext_reset_in = 1'b1;
        checkRestartSequence("powerup_again", 1'b0);

        // Randomized traffic against the reference model.
        rreq = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit ridle;
            bit rdone;
            if ($urandom_range(0, 15) == 0) rreq = ~rreq;
            ridle = ($urandom_range(0, 3) == 0);
            rdone = (m_phase == P_WAIT) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 31) == 0);
            applyStimulus(rreq, ridle, rdone);
            checkOutput("random", modelExpected());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
